// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, write-back/link port, issue marks and scoreboard status.
interface regfile_sb_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 32,
   parameter int unsigned NRD   = 2
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = $clog2(WIDTH / 8);

   logic [NRD*AW-1:0]    rd_addr_i;
   logic [NRD*WIDTH-1:0] rd_data_o;
   logic [NRD-1:0]       rd_busy_o;
   logic                 wr_en_i;
   logic [AW-1:0]        wr_addr_i;
   logic [WIDTH-1:0]     wr_data_i;
   logic [1:0]           wr_size_i;
   logic                 wr_unsigned_i;
   logic [OW-1:0]        wr_offset_i;
   logic                 link_en_i;
   logic                 issue_en_i;
   logic [AW-1:0]        issue_addr_i;
   logic                 misalign_o;
   logic [AW:0]          busy_cnt_o;

   modport master (
      output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_size_i, wr_unsigned_i,
             wr_offset_i, link_en_i, issue_en_i, issue_addr_i,
      input  rd_data_o, rd_busy_o, misalign_o, busy_cnt_o
   );

   modport slave (
      input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_size_i, wr_unsigned_i,
             wr_offset_i, link_en_i, issue_en_i, issue_addr_i,
      output rd_data_o, rd_busy_o, misalign_o, busy_cnt_o
   );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with combinational reads, extracting/extending write-back,
// forced link write, optional write-to-read bypass and a pending-write scoreboard.
module regfile_sb #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned NRD    = 2,
   parameter int unsigned RA_IDX = 1,
   parameter int unsigned BYPASS = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   regfile_sb_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [AW-1:0] RA = AW'(RA_IDX);

   logic [DEPTH-1:0][WIDTH-1:0] regs_q;
   logic [DEPTH-1:0]            busy_q;
   logic [DEPTH-1:0]            busy_d;
   logic [CW-1:0]               busy_cnt_q;
   logic [CW-1:0]               busy_cnt_d;
   logic                        misalign_q;

   logic [WIDTH-1:0] shifted_c;
   logic [WIDTH-1:0] mask_c;
   logic [WIDTH-1:0] ext_c;
   logic             sign_c;
   logic             misalign_c;
   logic             wr_do_c;

   // Operand extraction: sign comes from the operand's own MSB, not the bus MSB
   always_comb begin
      shifted_c  = bus.wr_data_i >> {bus.wr_offset_i, 3'b000};
      mask_c     = '1;
      sign_c     = 1'b0;
      misalign_c = 1'b0;
      case (bus.wr_size_i)
         2'b00: begin
            mask_c = WIDTH'(8'hFF);
            sign_c = shifted_c[7];
         end
         2'b01: begin
            mask_c     = WIDTH'(16'hFFFF);
            sign_c     = shifted_c[15];
            misalign_c = bus.wr_offset_i[0];
         end
         2'b10: begin
            mask_c     = WIDTH'(32'hFFFF_FFFF);
            sign_c     = shifted_c[31];
            misalign_c = |bus.wr_offset_i[1:0];
         end
         default: begin
            mask_c     = '1;
            sign_c     = 1'b0;
            misalign_c = |bus.wr_offset_i;
         end
      endcase
      if (bus.wr_unsigned_i) sign_c = 1'b0;
      ext_c   = (shifted_c & mask_c) | (sign_c ? ~mask_c : '0);
      wr_do_c = bus.wr_en_i && (bus.wr_addr_i != '0) && !misalign_c;
   end

   // Scoreboard next state: issue is applied last so a new producer wins
   always_comb begin
      busy_d = busy_q;
      if (wr_do_c)        busy_d[bus.wr_addr_i]  = 1'b0;
      if (bus.link_en_i)  busy_d[RA]             = 1'b0;
      if (bus.issue_en_i) busy_d[bus.issue_addr_i] = 1'b1;
      busy_d[0]  = 1'b0;
      busy_cnt_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
      end
   end

   // Link write is placed after the normal write so it takes priority
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         regs_q     <= '0;
         busy_q     <= '0;
         busy_cnt_q <= '0;
         misalign_q <= 1'b0;
      end else begin
         if (wr_do_c)       regs_q[bus.wr_addr_i] <= ext_c;
         if (bus.link_en_i) regs_q[RA]            <= bus.wr_data_i;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
         misalign_q <= bus.wr_en_i && misalign_c;
      end
   end

   assign bus.misalign_o = misalign_q;
   assign bus.busy_cnt_o = busy_cnt_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]    addr_c;
      logic [WIDTH-1:0] data_c;

      always_comb begin
         addr_c = bus.rd_addr_i[k*AW +: AW];
         data_c = regs_q[addr_c];
         if (BYPASS != 0) begin
            if (bus.link_en_i && (addr_c == RA))          data_c = bus.wr_data_i;
            else if (wr_do_c && (addr_c == bus.wr_addr_i)) data_c = ext_c;
         end
         if (addr_c == '0) data_c = '0;
      end

      assign bus.rd_data_o[k*WIDTH +: WIDTH] = data_c;
      assign bus.rd_busy_o[k]                = busy_q[addr_c];
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypassing and non-bypassing instances driven side by side
// and compared against an arithmetic reference model.
module tb_regfile_sb;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned NRD   = 2;
   localparam int unsigned AW    = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NRD*AW-1:0] rd_addr;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [31:0]       wr_data;
   logic [1:0]        wr_size;
   logic              wr_uns;
   logic [1:0]        wr_off;
   logic              link_en;
   logic              issue_en;
   logic [AW-1:0]     issue_addr;

   regfile_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) b1 ();
   regfile_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) b0 ();

   assign b1.rd_addr_i = rd_addr;      assign b0.rd_addr_i = rd_addr;
   assign b1.wr_en_i = wr_en;          assign b0.wr_en_i = wr_en;
   assign b1.wr_addr_i = wr_addr;      assign b0.wr_addr_i = wr_addr;
   assign b1.wr_data_i = wr_data;      assign b0.wr_data_i = wr_data;
   assign b1.wr_size_i = wr_size;      assign b0.wr_size_i = wr_size;
   assign b1.wr_unsigned_i = wr_uns;   assign b0.wr_unsigned_i = wr_uns;
   assign b1.wr_offset_i = wr_off;     assign b0.wr_offset_i = wr_off;
   assign b1.link_en_i = link_en;      assign b0.link_en_i = link_en;
   assign b1.issue_en_i = issue_en;    assign b0.issue_en_i = issue_en;
   assign b1.issue_addr_i = issue_addr; assign b0.issue_addr_i = issue_addr;

   regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .RA_IDX(1), .BYPASS(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));
   regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .RA_IDX(1), .BYPASS(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .bus(b0.slave));

   int checks = 0;
   int failures = 0;

   logic [31:0] mreg [DEPTH];
   logic        mbusy [DEPTH];
   int          mcnt;
   logic        mmis;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] s);
      int n;
      n = 1 << s;
      if (n > int'(WIDTH / 8)) n = int'(WIDTH / 8);
      return n;
   endfunction

   function automatic logic m_misaligned(input logic [1:0] s, input logic [1:0] o);
      return (int'(o) % nbytes(s)) != 0;
   endfunction

   // Take nb bits of the shifted word, then subtract 2^nb if a signed operand is negative
   function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [1:0] s,
                                         input logic u, input logic [1:0] o);
      longint unsigned op, lim;
      int nb;
      nb  = nbytes(s) * 8;
      op  = 64'(d) >> (8 * int'(o));
      lim = 64'd1 << nb;
      op  = op % lim;
      if (!u && s != 2'b11 && op >= lim / 2) op = op - lim;
      return 32'(op);
   endfunction

   function automatic logic m_wdo();
      return wr_en && (wr_addr != 0) && !m_misaligned(wr_size, wr_off);
   endfunction

   function automatic logic [31:0] exp_read(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp) begin
         if (link_en && a == 1) return wr_data;
         if (m_wdo() && a == wr_addr) return m_ext(wr_data, wr_size, wr_uns, wr_off);
      end
      return mreg[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) begin
         mreg[i]  = 32'h0;
         mbusy[i] = 1'b0;
      end
      mcnt = 0;
      mmis = 1'b0;
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_size = 2'b11; wr_uns = 1'b0;
      wr_off = '0; link_en = 1'b0; issue_en = 1'b0; issue_addr = '0;
   endtask

   task automatic set_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] s,
                         input logic u, input logic [1:0] o);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_size = s; wr_uns = u; wr_off = o;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic check_reads(input string tag);
      logic [AW-1:0] a;
      #1;
      for (int k = 0; k < int'(NRD); k++) begin
         a = rd_addr[k*AW +: AW];
         chk($sformatf("%s_p%0d_data_byp", tag, k), 64'(b1.rd_data_o[k*32 +: 32]), 64'(exp_read(a, 1'b1)));
         chk($sformatf("%s_p%0d_data_nobyp", tag, k), 64'(b0.rd_data_o[k*32 +: 32]), 64'(exp_read(a, 1'b0)));
         chk($sformatf("%s_p%0d_busy_byp", tag, k), 64'(b1.rd_busy_o[k]), 64'(mbusy[a]));
         chk($sformatf("%s_p%0d_busy_nobyp", tag, k), 64'(b0.rd_busy_o[k]), 64'(mbusy[a]));
      end
   endtask

   // Advance one clock, update the model from the inputs held over the edge, check status
   task automatic cycle(input string tag);
      logic        mis, wdo;
      logic [31:0] ext;
      mis = wr_en && m_misaligned(wr_size, wr_off);
      wdo = m_wdo();
      ext = m_ext(wr_data, wr_size, wr_uns, wr_off);
      @(posedge clk);
      #1;
      if (wdo) begin mreg[wr_addr] = ext; mbusy[wr_addr] = 1'b0; end
      if (link_en) begin mreg[1] = wr_data; mbusy[1] = 1'b0; end
      if (issue_en && issue_addr != 0) mbusy[issue_addr] = 1'b1;
      mmis = mis;
      mcnt = 0;
      for (int i = 0; i < int'(DEPTH); i++) mcnt += int'(mbusy[i]);
      chk({tag, "_mis_byp"}, 64'(b1.misalign_o), 64'(mmis));
      chk({tag, "_mis_nobyp"}, 64'(b0.misalign_o), 64'(mmis));
      chk({tag, "_cnt_byp"}, 64'(b1.busy_cnt_o), 64'(mcnt));
      chk({tag, "_cnt_nobyp"}, 64'(b0.busy_cnt_o), 64'(mcnt));
   endtask

   initial begin
      idle();
      set_rd(5'd5, 5'd0);
      model_reset();
      #3;
      check_reads("reset");
      chk("reset_cnt", 64'(b1.busy_cnt_o), 64'd0);
      chk("reset_mis", 64'(b1.misalign_o), 64'd0);
      #5 rst_n = 1'b1;
      @(posedge clk); #1;

      // Full write to x5, then to x0
      set_wr(5'd5, 32'h1234_5678, 2'b11, 1'b0, 2'd0);
      check_reads("w5");
      cycle("w5");
      idle(); set_wr(5'd0, 32'hFFFF_FFFF, 2'b11, 1'b0, 2'd0);
      check_reads("w0");
      chk("x5_lit", 64'(b1.rd_data_o[31:0]), 64'h1234_5678);
      cycle("w0");
      idle(); set_rd(5'd0, 5'd5);
      check_reads("r0");
      chk("x0_lit", 64'(b1.rd_data_o[31:0]), 64'h0);

      // Byte extraction at various lanes
      set_wr(5'd3, 32'h80FF_7F00, 2'b00, 1'b0, 2'd1); set_rd(5'd3, 5'd3);
      cycle("b1s");
      idle(); check_reads("b1s_r");
      chk("x3_b1s_lit", 64'(b1.rd_data_o[31:0]), 64'h0000_007F);
      set_wr(5'd3, 32'h80FF_7F00, 2'b00, 1'b0, 2'd3);
      cycle("b3s");
      idle(); check_reads("b3s_r");
      chk("x3_b3s_lit", 64'(b1.rd_data_o[31:0]), 64'hFFFF_FF80);
      set_wr(5'd3, 32'h80FF_7F00, 2'b00, 1'b1, 2'd3);
      cycle("b3u");
      idle(); check_reads("b3u_r");
      chk("x3_b3u_lit", 64'(b1.rd_data_o[31:0]), 64'h0000_0080);

      // Misaligned half to busy x7 is dropped
      set_wr(5'd7, 32'h0000_00AA, 2'b11, 1'b0, 2'd0);
      issue_en = 1'b1; issue_addr = 5'd7;
      cycle("w7");
      idle(); set_wr(5'd7, 32'h0000_FFFF, 2'b01, 1'b0, 2'd1); set_rd(5'd7, 5'd7);
      check_reads("mis_w");
      cycle("mis");
      chk("mis_pulse_lit", 64'(b1.misalign_o), 64'd1);
      idle(); check_reads("mis_r");
      chk("x7_lit", 64'(b1.rd_data_o[31:0]), 64'h0000_00AA);
      chk("x7_busy_lit", 64'(b1.rd_busy_o[0]), 64'd1);
      cycle("mis_end");
      chk("mis_drop_lit", 64'(b1.misalign_o), 64'd0);
      set_wr(5'd7, 32'h0000_00AA, 2'b11, 1'b0, 2'd0);
      cycle("w7_clr");

      // Same-cycle read of the register being written
      idle(); set_wr(5'd9, 32'hDEAD_BEEF, 2'b11, 1'b0, 2'd0); set_rd(5'd9, 5'd9);
      check_reads("byp");
      chk("byp1_lit", 64'(b1.rd_data_o[63:32]), 64'hDEAD_BEEF);
      chk("byp0_lit", 64'(b0.rd_data_o[63:32]), 64'h0);
      cycle("byp");

      // Scoreboard
      idle(); issue_en = 1'b1; issue_addr = 5'd4; cycle("iss4");
      issue_addr = 5'd6; cycle("iss6");
      chk("cnt2_lit", 64'(b1.busy_cnt_o), 64'd2);
      idle(); set_rd(5'd4, 5'd6); check_reads("sb_r");
      chk("busy4_lit", 64'(b1.rd_busy_o[0]), 64'd1);
      set_wr(5'd4, 32'h1, 2'b11, 1'b0, 2'd0); cycle("w4");
      chk("cnt1_lit", 64'(b1.busy_cnt_o), 64'd1);
      set_wr(5'd6, 32'h2, 2'b11, 1'b0, 2'd0); issue_en = 1'b1; issue_addr = 5'd6;
      cycle("iw6");
      chk("cnt_iw6_lit", 64'(b1.busy_cnt_o), 64'd1);
      idle(); check_reads("iw6_r");
      chk("busy6_lit", 64'(b1.rd_busy_o[1]), 64'd1);

      // Link write beats a normal write to x1
      set_wr(5'd1, 32'h0000_1004, 2'b00, 1'b0, 2'd0); link_en = 1'b1; set_rd(5'd1, 5'd1);
      check_reads("link");
      cycle("link");
      idle(); check_reads("link_r");
      chk("x1_lit", 64'(b1.rd_data_o[31:0]), 64'h0000_1004);

      // Asynchronous reset away from any clock edge
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_x1_byp", 64'(b1.rd_data_o[31:0]), 64'h0);
      chk("arst_x1_nobyp", 64'(b0.rd_data_o[31:0]), 64'h0);
      chk("arst_cnt_byp", 64'(b1.busy_cnt_o), 64'd0);
      chk("arst_cnt_nobyp", 64'(b0.busy_cnt_o), 64'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         wr_en      = ($urandom_range(0, 3) != 0);
         wr_addr    = AW'($urandom);
         wr_data    = $urandom;
         wr_size    = 2'($urandom);
         wr_uns     = 1'($urandom);
         wr_off     = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'($urandom);
         link_en    = ($urandom_range(0, 7) == 0);
         issue_en   = ($urandom_range(0, 1) != 0);
         issue_addr = AW'($urandom);
         rd_addr    = (NRD*AW)'($urandom);
         check_reads("rnd");
         cycle("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
